// File: rtl/bin_ext_gcd_pkg.sv
// Shared types and constants for the extended-GCD inverse normaliser.
package bin_ext_gcd_pkg;

  localparam int DEF_NBITS    = 2048;
  localparam int DEF_MAX_ITER = 4;
  localparam int ITER_W       = $clog2(DEF_MAX_ITER + 1);

  // Two-bit state encoding shared by the FSM and any debug taps
  typedef logic [1:0] inv_state_t;
  localparam inv_state_t S_IDLE  = 2'd0;
  localparam inv_state_t S_CHECK = 2'd1;
  localparam inv_state_t S_NORM  = 2'd2;
  localparam inv_state_t S_DONE  = 2'd3;

  function automatic int iter_width(input int max_iter);
    return $clog2(max_iter + 1);
  endfunction

endpackage

// File: rtl/bin_ext_gcd_inv_norm_step.sv
// One residue-normalisation step: sign/range test plus a conditional modulus add or subtract.
module inv_norm_step #(
  parameter int NBITS = 8
) (
  input  logic signed [NBITS+2:0] coef_i,
  input  logic        [NBITS-1:0] mod_i,
  output logic signed [NBITS+2:0] coef_o,
  output logic                    in_range_o
);

  logic signed [NBITS+2:0] mod_ext;
  logic                    neg;
  logic                    ge_mod;

  assign mod_ext = signed'({3'b000, mod_i});
  assign neg     = coef_i[NBITS+2];
  assign ge_mod  = unsigned'(coef_i) >= unsigned'(mod_ext);

  assign in_range_o = !neg && !ge_mod;
  // Out-of-range coefficients move one modulus towards [0, mod)
  assign coef_o     = neg ? (coef_i + mod_ext) : (coef_i - mod_ext);

endmodule

// File: rtl/bin_ext_gcd_inv_norm.sv
// Normalises an extended-GCD Bezout coefficient into a canonical inverse in [0, modulus).
// Optional cycle counter output enabled by defining INV_NORM_CYC_CNT_EN.
module bin_ext_gcd_inv_norm
  import bin_ext_gcd_pkg::*;
#(
  parameter int NBITS    = DEF_NBITS,
  parameter int MAX_ITER = DEF_MAX_ITER
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_p,
  input  logic signed [NBITS+2:0] coef_in,
  input  logic        [NBITS-1:0] gcd_in,
  input  logic        [NBITS-1:0] modulus,
  output logic        [NBITS-1:0] inv,
  output logic                    done_p,
  output logic                    err_p,
`ifdef INV_NORM_CYC_CNT_EN
  output logic        [7:0]       cyc_cnt,
`endif
  output logic                    busy
);

  localparam int IW = iter_width(MAX_ITER);
  localparam logic [NBITS-1:0] ONE      = NBITS'(1);
  localparam logic [IW-1:0]    ITER_MAX = IW'(MAX_ITER);

  inv_state_t              state_q, state_d;
  logic signed [NBITS+2:0] coef_q,  coef_d;
  logic        [NBITS-1:0] mod_q,   mod_d;
  logic        [NBITS-1:0] gcd_q,   gcd_d;
  logic        [NBITS-1:0] inv_q,   inv_d;
  logic        [IW-1:0]    iter_q,  iter_d;
  logic                    err_q,   err_d;

  logic signed [NBITS+2:0] step_coef;
  logic                    step_in_range;

  inv_norm_step #(.NBITS(NBITS)) u_step (
    .coef_i     (coef_q),
    .mod_i      (mod_q),
    .coef_o     (step_coef),
    .in_range_o (step_in_range)
  );

  always_comb begin
    state_d = state_q;
    coef_d  = coef_q;
    mod_d   = mod_q;
    gcd_d   = gcd_q;
    inv_d   = inv_q;
    iter_d  = iter_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_p) begin
          coef_d  = coef_in;
          gcd_d   = gcd_in;
          mod_d   = modulus;
          iter_d  = '0;
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (gcd_q != ONE || mod_q == '0) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (step_in_range) begin
          inv_d   = coef_q[NBITS-1:0];
          state_d = S_DONE;
        end else if (iter_q == ITER_MAX) begin
          // Correction budget exhausted: report failure, keep the old inverse
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          coef_d  = step_coef;
          iter_d  = iter_q + IW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      coef_q  <= '0;
      mod_q   <= '0;
      gcd_q   <= '0;
      inv_q   <= '0;
      iter_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      coef_q  <= coef_d;
      mod_q   <= mod_d;
      gcd_q   <= gcd_d;
      inv_q   <= inv_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
    end
  end

  assign inv    = inv_q;
  assign done_p = (state_q == S_DONE);
  assign err_p  = (state_q == S_DONE) && err_q;
  assign busy   = (state_q != S_IDLE);

`ifdef INV_NORM_CYC_CNT_EN
  logic [7:0] cyc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
    end else if (state_q == S_IDLE && start_p) begin
      cyc_q <= '0;
    end else if (busy && cyc_q != 8'hFF) begin
      cyc_q <= cyc_q + 8'd1;
    end
  end

  assign cyc_cnt = cyc_q;
`endif

endmodule
